// File: rtl/pea_kxk.sv
// KxK convolution PE array: COL output rows per image column, DEPTH-entry partial-sum bank.
// Latency: a window's sum lands in the accumulator 2 cycles after its completing ifm beat.
// Backpressure: each stream advances only on valid&ready; out_data/out_mask hold while out_ready is low.
module pea_kxk #(
  parameter int K     = 3,
  parameter int COL   = 8,
  parameter int DW    = 8,
  parameter int PW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    cfg_stride,
  input  logic [AW-1:0]           cfg_len_m1,
  input  logic                    ic_last,
  output logic                    busy,
  input  logic                    wgt_valid,
  output logic                    wgt_ready,
  input  logic [K*DW-1:0]         wgt_data,
  input  logic                    ifm_valid,
  output logic                    ifm_ready,
  input  logic [(COL+K-1)*DW-1:0] ifm_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COL*PW-1:0]       out_data,
  output logic [COL-1:0]          out_mask,
  output logic                    done
);

  localparam int LN = COL + K - 1;
  // Wide enough for the longest stride-2 beat count.
  localparam int CW = $clog2(2 * DEPTH + K + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WLOAD  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stride_q, stride_d;
  logic [AW-1:0] len_m1_q, len_m1_d;
  logic          last_q, last_d;
  logic          fresh_q, fresh_d;
  logic          done_q, done_d;

  logic signed [DW-1:0]   w_q   [K][K];
  logic signed [DW-1:0]   win_q [LN][K];
  logic                   win_vld_q, win_vld_d;
  logic [AW-1:0]          win_addr_q, win_addr_d;
  logic signed [2*DW-1:0] prod_q [COL][K][K];
  logic                   p1_vld_q;
  logic [AW-1:0]          p1_addr_q;
  logic signed [PW-1:0]   sum_c [COL];
  logic [PW-1:0]          acc_q [DEPTH][COL];

  logic          wgt_xfer, ifm_xfer;
  logic [CW-1:0] stream_last, cnt_inc, win_idx;

  assign wgt_xfer = (state_q == S_WLOAD) && wgt_valid;
  assign ifm_xfer = (state_q == S_STREAM) && ifm_valid;
  assign cnt_inc  = cnt_q + CW'(1);
  // Window index completed by the beat being accepted now.
  assign win_idx  = cnt_inc - CW'(K);
  assign stream_last = stride_q ? ((CW'(len_m1_q) << 1) + CW'(K - 1))
                                : (CW'(len_m1_q) + CW'(K - 1));

  // Pass sequencing: one shared counter tracks weight beats, ifm beats, drain cycles and out address.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stride_d = stride_q;
    len_m1_d = len_m1_q;
    last_d   = last_q;
    fresh_d  = fresh_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        stride_d = cfg_stride;
        len_m1_d = cfg_len_m1;
        last_d   = ic_last;
        cnt_d    = '0;
        state_d  = S_WLOAD;
      end
      S_WLOAD: if (wgt_valid) begin
        if (cnt_q == CW'(K - 1)) begin
          cnt_d   = '0;
          state_d = S_STREAM;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_STREAM: if (ifm_valid) begin
        if (cnt_q == stream_last) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          fresh_d = 1'b0;
          if (last_q) begin
            state_d = S_OUT;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_OUT: if (out_ready) begin
        if (cnt_q == CW'(len_m1_q)) begin
          cnt_d   = '0;
          fresh_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; reset lands in IDLE with the bank marked fresh.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      stride_q <= 1'b0;
      len_m1_q <= '0;
      last_q   <= 1'b0;
      fresh_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stride_q <= stride_d;
      len_m1_q <= len_m1_d;
      last_q   <= last_d;
      fresh_q  <= fresh_d;
      done_q   <= done_d;
    end
  end

  // Weight beat j loads kernel column j for every kernel row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < K; r++)
        for (int j = 0; j < K; j++)
          w_q[r][j] <= '0;
    end else if (wgt_xfer) begin
      for (int j = 0; j < K; j++)
        if (cnt_q == CW'(j))
          for (int r = 0; r < K; r++)
            w_q[r][j] <= wgt_data[r*DW +: DW];
    end
  end

  // A window is written for every completed w (stride 1) or even w only (stride 2).
  always_comb begin
    win_vld_d  = ifm_xfer && (cnt_inc >= CW'(K)) && (!stride_q || !win_idx[0]);
    win_addr_d = stride_q ? AW'(win_idx >> 1) : AW'(win_idx);
  end

  // Per-lane K-deep shift register, oldest column at index 0; emptied while weights load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LN; i++)
        for (int j = 0; j < K; j++)
          win_q[i][j] <= '0;
      win_vld_q  <= 1'b0;
      win_addr_q <= '0;
    end else begin
      win_vld_q  <= win_vld_d;
      win_addr_q <= win_addr_d;
      if (state_q == S_WLOAD) begin
        for (int i = 0; i < LN; i++)
          for (int j = 0; j < K; j++)
            win_q[i][j] <= '0;
      end else if (ifm_xfer) begin
        for (int i = 0; i < LN; i++) begin
          for (int j = 0; j < K - 1; j++)
            win_q[i][j] <= win_q[i][j+1];
          win_q[i][K-1] <= ifm_data[i*DW +: DW];
        end
      end
    end
  end

  // Stage 1: all K*K*COL products, free-running so ifm stalls never delay a write.
  always_ff @(posedge clk) begin
    for (int c = 0; c < COL; c++)
      for (int r = 0; r < K; r++)
        for (int j = 0; j < K; j++)
          prod_q[c][r][j] <= (2*DW)'(win_q[r+c][j]) * (2*DW)'(w_q[r][j]);
  end

  // Stage-1 tag travels alongside the products.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p1_vld_q  <= 1'b0;
      p1_addr_q <= '0;
    end else begin
      p1_vld_q  <= win_vld_q;
      p1_addr_q <= win_addr_q;
    end
  end

  // Stage 2 adder tree: sign-extend each product and sum per output row.
  always_comb begin
    for (int c = 0; c < COL; c++) begin
      sum_c[c] = '0;
      for (int r = 0; r < K; r++)
        for (int j = 0; j < K; j++)
          sum_c[c] = sum_c[c] + PW'(prod_q[c][r][j]);
    end
  end

  // Partial-sum bank: first channel overwrites, later channels accumulate (wrapping).
  always_ff @(posedge clk) begin
    if (p1_vld_q)
      for (int c = 0; c < COL; c++)
        acc_q[p1_addr_q][c] <= fresh_q ? PW'(sum_c[c]) : acc_q[p1_addr_q][c] + PW'(sum_c[c]);
  end

  assign busy      = (state_q != S_IDLE);
  assign wgt_ready = (state_q == S_WLOAD);
  assign ifm_ready = (state_q == S_STREAM);
  assign out_valid = (state_q == S_OUT);
  assign done      = done_q;

  // Result beat reads straight from the bank; address only moves on a handshake, so stalls hold it.
  always_comb begin
    for (int c = 0; c < COL; c++) begin
      out_data[c*PW +: PW] = out_valid ? acc_q[cnt_q[AW-1:0]][c] : '0;
      out_mask[c]          = out_valid && (!stride_q || (c % 2 == 0));
    end
  end

endmodule

// File: tb/tb_pea_kxk.sv
module tb_pea_kxk;
  localparam int K = 3, COL = 8, DW = 8, PW = 32, DEPTH = 16, AW = 4;
  localparam int LN = COL + K - 1;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
  logic                cfg_stride = 1'b0;
  logic [AW-1:0]       cfg_len_m1 = '0;
  logic                ic_last = 1'b0;
  logic                busy;
  logic                wgt_valid = 1'b0;
  logic                wgt_ready;
  logic [K*DW-1:0]     wgt_data = '0;
  logic                ifm_valid = 1'b0;
  logic                ifm_ready;
  logic [LN*DW-1:0]    ifm_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [COL*PW-1:0]   out_data;
  logic [COL-1:0]      out_mask;
  logic                done;

  pea_kxk #(.K(K), .COL(COL), .DW(DW), .PW(PW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_stride(cfg_stride), .cfg_len_m1(cfg_len_m1),
    .ic_last(ic_last), .busy(busy), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
    .wgt_data(wgt_data), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [COL*PW-1:0] obs_dat [32];
  logic [COL-1:0]    obs_msk [32];
  int n_ifm, n_out, n_done;
  bit tmo, stable;

  // Drives one pass and records what the DUT did; checks are done by the callers.
  task automatic run_pass(input logic stride, input logic [AW-1:0] len_m1, input logic last,
                          input logic [DW-1:0] wval, input logic [DW-1:0] ival, input bit ramp,
                          input int bp_beat, input int bp_cycles, input bit noisy, input int rst_at);
    int wbeats, stall_cnt, stream_cyc;
    logic [COL*PW-1:0] stall_dat;
    logic [COL-1:0]    stall_msk;
    n_ifm = 0; n_out = 0; n_done = 0; tmo = 1; stable = 1;
    wbeats = 0; stall_cnt = 0; stream_cyc = 0;
    stall_dat = '0; stall_msk = '0;
    for (int b = 0; b < 32; b++) begin obs_dat[b] = '0; obs_msk[b] = '0; end
    @(posedge clk); #1;
    cfg_stride = stride; cfg_len_m1 = len_m1; ic_last = last; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_stride = ~stride; cfg_len_m1 = ~len_m1; ic_last = ~last;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) begin n_done++; tmo = 0; break; end
      if (rst_at > 0 && ifm_ready) begin
        stream_cyc++;
        if (stream_cyc == rst_at) begin rstn = 1'b0; tmo = 0; break; end
      end
      start = noisy && busy && ($urandom_range(0, 1) == 1);
      wgt_valid = (wbeats < K);
      for (int r = 0; r < K; r++) wgt_data[r*DW +: DW] = wval;
      if (wgt_valid && wgt_ready) wbeats++;
      ifm_valid = noisy ? ($urandom_range(0, 1) == 1) : 1'b1;
      for (int i = 0; i < LN; i++) ifm_data[i*DW +: DW] = ramp ? DW'(n_ifm) : ival;
      if (ifm_valid && ifm_ready) n_ifm++;
      if (bp_cycles > 0 && stall_cnt == 0 && out_valid && n_out == bp_beat) begin
        stall_dat = out_data; stall_msk = out_mask; out_ready = 1'b0; stall_cnt = 1;
      end else if (stall_cnt > 0 && stall_cnt < bp_cycles) begin
        if (!out_valid || out_data !== stall_dat || out_mask !== stall_msk) stable = 0;
        out_ready = 1'b0; stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (stall_cnt > 0 && n_out == bp_beat && out_data !== stall_dat) stable = 0;
        if (n_out < 32) begin obs_dat[n_out] = out_data; obs_msk[n_out] = out_mask; end
        n_out++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; wgt_valid = 1'b0; ifm_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (wgt_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wgt_ready got=%b want=0", wgt_ready); end
    n_cmp++; if (ifm_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ifm_ready got=%b want=0", ifm_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    n_cmp++; if (out_mask !== '0) begin n_bad++; $display("FAIL reset_out_mask got=%h want=0", out_mask); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    run_pass(1'b0, 4'd3, 1'b1, 8'd1, 8'd1, 1'b0, -1, 0, 1'b0, 0);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL basic_timeout got=%0d want=0", tmo); end
    n_cmp++; if (n_ifm != 6) begin n_bad++; $display("FAIL basic_ifm_beats got=%0d want=6", n_ifm); end
    n_cmp++; if (n_out != 4) begin n_bad++; $display("FAIL basic_out_beats got=%0d want=4", n_out); end
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL basic_done got=%0d want=1", n_done); end
    for (int b = 0; b < 4; b++) begin
      n_cmp++; if (obs_msk[b] !== 8'hFF) begin n_bad++; $display("FAIL basic_mask beat=%0d got=%h want=ff", b, obs_msk[b]); end
      for (int c = 0; c < COL; c++) begin
        n_cmp++;
        if (obs_dat[b][c*PW +: PW] !== 32'd9) begin
          n_bad++; $display("FAIL basic_lane beat=%0d lane=%0d got=%0d want=9", b, c, obs_dat[b][c*PW +: PW]);
        end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got=%b want=0", done); end
  endtask

  task automatic test_two_pass();
    run_pass(1'b0, 4'd3, 1'b0, 8'd1, 8'd1, 1'b0, -1, 0, 1'b0, 0);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL two_p1_timeout got=%0d want=0", tmo); end
    n_cmp++; if (n_out != 0) begin n_bad++; $display("FAIL two_p1_out_beats got=%0d want=0", n_out); end
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL two_p1_done got=%0d want=1", n_done); end
    run_pass(1'b0, 4'd3, 1'b1, 8'd2, 8'd1, 1'b0, -1, 0, 1'b0, 0);
    n_cmp++; if (n_out != 4) begin n_bad++; $display("FAIL two_p2_out_beats got=%0d want=4", n_out); end
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < COL; c++) begin
        n_cmp++;
        if (obs_dat[b][c*PW +: PW] !== 32'd27) begin
          n_bad++; $display("FAIL two_lane beat=%0d lane=%0d got=%0d want=27", b, c, obs_dat[b][c*PW +: PW]);
        end
      end
  endtask

  task automatic test_stride2();
    logic [PW-1:0] want;
    run_pass(1'b1, 4'd2, 1'b1, 8'd1, 8'd0, 1'b1, -1, 0, 1'b0, 0);
    n_cmp++; if (n_ifm != 7) begin n_bad++; $display("FAIL s2_ifm_beats got=%0d want=7", n_ifm); end
    n_cmp++; if (n_out != 3) begin n_bad++; $display("FAIL s2_out_beats got=%0d want=3", n_out); end
    for (int b = 0; b < 3; b++) begin
      want = PW'(18 * b + 9);
      n_cmp++; if (obs_msk[b] !== 8'h55) begin n_bad++; $display("FAIL s2_mask beat=%0d got=%h want=55", b, obs_msk[b]); end
      for (int c = 0; c < COL; c++) begin
        n_cmp++;
        if (obs_dat[b][c*PW +: PW] !== want) begin
          n_bad++; $display("FAIL s2_lane beat=%0d lane=%0d got=%0d want=%0d", b, c, obs_dat[b][c*PW +: PW], want);
        end
      end
    end
  endtask

  // Ramp data gives distinct beat values (9, 18, 27, 36) so order is visible.
  task automatic test_backpressure();
    logic [PW-1:0] want;
    run_pass(1'b0, 4'd3, 1'b1, 8'd1, 8'd0, 1'b1, 1, 5, 1'b0, 0);
    n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL bp_stable got=%0d want=1", stable); end
    n_cmp++; if (n_out != 4) begin n_bad++; $display("FAIL bp_out_beats got=%0d want=4", n_out); end
    for (int b = 0; b < 4; b++) begin
      want = PW'(9 * b + 9);
      n_cmp++;
      if (obs_dat[b][0 +: PW] !== want || obs_dat[b][(COL-1)*PW +: PW] !== want) begin
        n_bad++; $display("FAIL bp_order beat=%0d got=%0d/%0d want=%0d", b, obs_dat[b][0 +: PW], obs_dat[b][(COL-1)*PW +: PW], want);
      end
    end
  endtask

  task automatic test_signed();
    run_pass(1'b0, 4'd3, 1'b1, 8'h80, 8'd127, 1'b0, -1, 0, 1'b0, 0);
    n_cmp++; if (n_out != 4) begin n_bad++; $display("FAIL signed_out_beats got=%0d want=4", n_out); end
    for (int c = 0; c < COL; c++) begin
      n_cmp++;
      if (obs_dat[2][c*PW +: PW] !== 32'hFFFDC480) begin
        n_bad++; $display("FAIL signed_lane lane=%0d got=%h want=fffdc480", c, obs_dat[2][c*PW +: PW]);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_pass(1'b0, 4'd3, 1'b0, 8'd1, 8'd1, 1'b0, -1, 0, 1'b0, 0);
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL rmid_p1_done got=%0d want=1", n_done); end
    run_pass(1'b0, 4'd3, 1'b0, 8'd5, 8'd5, 1'b0, -1, 0, 1'b0, 3);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    n_cmp++; if (ifm_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ifm_ready got=%b want=0", ifm_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
    @(posedge clk); #1;
    rstn = 1'b1;
    run_pass(1'b0, 4'd3, 1'b1, 8'd1, 8'd1, 1'b0, -1, 0, 1'b0, 0);
    n_cmp++; if (n_out != 4) begin n_bad++; $display("FAIL rmid_out_beats got=%0d want=4", n_out); end
    for (int b = 0; b < 4; b++) begin
      n_cmp++;
      if (obs_dat[b][0 +: PW] !== 32'd9 || obs_dat[b][(COL-1)*PW +: PW] !== 32'd9) begin
        n_bad++; $display("FAIL rmid_lane beat=%0d got=%0d/%0d want=9", b, obs_dat[b][0 +: PW], obs_dat[b][(COL-1)*PW +: PW]);
      end
    end
  endtask

  task automatic test_noisy_inputs();
    run_pass(1'b0, 4'd3, 1'b1, 8'd1, 8'd1, 1'b0, -1, 0, 1'b1, 0);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL noisy_timeout got=%0d want=0", tmo); end
    n_cmp++; if (n_ifm != 6) begin n_bad++; $display("FAIL noisy_ifm_beats got=%0d want=6", n_ifm); end
    n_cmp++; if (n_out != 4) begin n_bad++; $display("FAIL noisy_out_beats got=%0d want=4", n_out); end
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL noisy_done got=%0d want=1", n_done); end
    for (int b = 0; b < 4; b++) begin
      n_cmp++; if (obs_msk[b] !== 8'hFF) begin n_bad++; $display("FAIL noisy_mask beat=%0d got=%h want=ff", b, obs_msk[b]); end
      for (int c = 0; c < COL; c++) begin
        n_cmp++;
        if (obs_dat[b][c*PW +: PW] !== 32'd9) begin
          n_bad++; $display("FAIL noisy_lane beat=%0d lane=%0d got=%0d want=9", b, c, obs_dat[b][c*PW +: PW]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_pass();
    test_stride2();
    test_backpressure();
    test_signed();
    test_reset_mid();
    test_noisy_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
